// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: read pointer, memory address, empty/level status.
// Latency: rd_addr combinational from the pointer register; status, rptr_gray, rd_valid one edge after rd_fire.
// Backpressure: a read is accepted only while empty=0; a read while empty is dropped and flagged on underflow.
module fifo_rd_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned PTR_W     = ADDR_W + 1,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  wptr_gray_sync,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [PTR_W-1:0]  rptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [PTR_W-1:0]  rd_level,
  output logic              rd_valid,
  output logic              underflow
);

  logic [PTR_W-1:0] rbin_q, rbin_d;
  logic [PTR_W-1:0] rgray_q, rgray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wbin;
  logic             empty_q, empty_d;
  logic             ae_q, ae_d;
  logic             valid_q, under_q;
  logic             rd_fire;

  // The empty flag gates every read, so a read can never overtake the writer.
  assign rd_fire = rd_en & ~empty_q;

  // Decode the synchronised write pointer: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      wbin[i] = ^(wptr_gray_sync >> i);
    end
  end

  // Next pointer and status, all computed from the post-read pointer so empty asserts on the last read's edge.
  always_comb begin
    rbin_d  = rbin_q + {{(PTR_W-1){1'b0}}, rd_fire};
    rgray_d = rbin_d ^ (rbin_d >> 1);
    empty_d = (rgray_d == wptr_gray_sync);
    level_d = wbin - rbin_d;
    ae_d    = (level_d <= PTR_W'(AE_THRESH));
  end

  // State registers; reset leaves the FIFO looking empty with no pending read or underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      level_q <= '0;
      valid_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      level_q <= level_d;
      valid_q <= rd_fire;
      under_q <= rd_en & empty_q;
    end
  end

  // rptr_gray leaves straight from a flop so the crossing never sees combinational glitches.
  assign rd_addr      = rbin_q[ADDR_W-1:0];
  assign rptr_gray    = rgray_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_level     = level_q;
  assign rd_valid     = valid_q;
  assign underflow    = under_q;

endmodule
